fetch_sequencer: RTL

//  Instruction-fetch controller between the 16-bit multicycle processor and its word memory.

---
 rtl/fetch_sequencer_pkg.sv | 19 +
 rtl/fetch_sequencer_if.sv | 31 +++
 rtl/fetch_sequencer_pc_register.sv | 21 ++
 rtl/fetch_sequencer.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/fetch_sequencer_pkg.sv
// Shared types and defaults for the instruction-fetch sequencer.
package fetch_sequencer_pkg;

  localparam int DEF_ADDR_W = 5;
  localparam int DEF_DATA_W = 16;

  typedef enum logic [1:0] {
    FS_IDLE  = 2'd0,
    FS_FETCH = 2'd1,
    FS_EXEC  = 2'd2,
    FS_LOAD  = 2'd3
  } fs_state_t;

  // Width needed for a counter running 0..lat inclusive.
  function automatic int cnt_width(input int lat);
    return (lat < 1) ? 1 : $clog2(lat + 1);
  endfunction

endpackage

// File: rtl/fetch_sequencer_if.sv
// Loader, memory and processor-side signals of the fetch sequencer.
interface fetch_sequencer_if
  import fetch_sequencer_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
);

  logic              LoadReq;
  logic [ADDR_W-1:0] LoadAddr;
  logic [DATA_W-1:0] LoadData;
  logic              LoadAck;
  logic [ADDR_W-1:0] MemAddr;
  logic [DATA_W-1:0] MemData;
  logic              MemWren;
  logic [DATA_W-1:0] MemQ;
  logic [DATA_W-1:0] ProcDIN;
  logic              ProcRun;
  logic              ProcDone;

  modport master (
    input  LoadReq, LoadAddr, LoadData, MemQ, ProcDone,
    output LoadAck, MemAddr, MemData, MemWren, ProcDIN, ProcRun
  );

  modport slave (
    output LoadReq, LoadAddr, LoadData, MemQ, ProcDone,
    input  LoadAck, MemAddr, MemData, MemWren, ProcDIN, ProcRun
  );

endinterface

// File: rtl/fetch_sequencer_pc_register.sv
// Program counter: async reset to START_ADDR, increments modulo 2**ADDR_W.
module pc_register
  import fetch_sequencer_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int START_ADDR = 0
) (
  input  logic              Clock,
  input  logic              Resetn,
  input  logic              inc,
  output logic [ADDR_W-1:0] pc
);

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn)
      pc <= ADDR_W'(START_ADDR);
    else if (inc)
      pc <= pc + ADDR_W'(1);
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch controller: drives memory from the PC, feeds the processor, arbitrates loader writes.
// Optional breakpoint support is enabled with FETCH_SEQ_BREAKPOINT_EN.
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int MEM_LAT    = 1,
  parameter int START_ADDR = 0
) (
  input  logic              Clock,
  input  logic              Resetn,
  input  logic              Start,
  input  logic              Halt,
`ifdef FETCH_SEQ_BREAKPOINT_EN
  input  logic [ADDR_W-1:0] BpAddr,
  input  logic              BpEnable,
  output logic              BpHit,
`endif
  fetch_sequencer_if.master bus,
  output logic [ADDR_W-1:0] PC,
  output logic              Busy
);

  localparam int CNT_W = cnt_width(MEM_LAT);

  fs_state_t         state, state_next;
  logic              ret_exec, ret_exec_next;
  logic              latch_load;
  logic              pc_inc;
  logic              fetch_done;
  logic [ADDR_W-1:0] pc_plus1;
  logic [ADDR_W-1:0] load_addr;
  logic [DATA_W-1:0] load_data;
  logic [CNT_W-1:0]  lat_cnt;
`ifdef FETCH_SEQ_BREAKPOINT_EN
  logic              bp_set;
  logic              bp_clear;
`endif

  pc_register #(
    .ADDR_W     (ADDR_W),
    .START_ADDR (START_ADDR)
  ) u_pc (
    .Clock  (Clock),
    .Resetn (Resetn),
    .inc    (pc_inc),
    .pc     (PC)
  );

  assign pc_plus1   = PC + ADDR_W'(1);
  assign fetch_done = (state == FS_FETCH) && (lat_cnt == CNT_W'(MEM_LAT));

  assign bus.MemAddr = (state == FS_LOAD) ? load_addr : PC;
  assign bus.MemData = load_data;
  assign bus.MemWren = (state == FS_LOAD);
  assign bus.LoadAck = (state == FS_LOAD);
  assign bus.ProcRun = (state == FS_EXEC);
  assign Busy        = (state != FS_IDLE);

  always_comb begin
    state_next    = state;
    ret_exec_next = ret_exec;
    latch_load    = 1'b0;
    pc_inc        = 1'b0;
`ifdef FETCH_SEQ_BREAKPOINT_EN
    bp_set        = 1'b0;
    bp_clear      = 1'b0;
`endif
    case (state)
      FS_IDLE: begin
        if (bus.LoadReq) begin
          latch_load    = 1'b1;
          ret_exec_next = 1'b0;
          state_next    = FS_LOAD;
        end else if (Start) begin
          state_next = FS_FETCH;
`ifdef FETCH_SEQ_BREAKPOINT_EN
          bp_clear   = 1'b1;
`endif
        end
      end
      FS_FETCH: begin
        if (fetch_done)
          state_next = FS_EXEC;
      end
      FS_EXEC: begin
        // A Done in the same cycle as a load request wins; the load stays pending.
        if (bus.ProcDone) begin
          pc_inc     = 1'b1;
          state_next = Halt ? FS_IDLE : FS_FETCH;
`ifdef FETCH_SEQ_BREAKPOINT_EN
          if (BpEnable && (pc_plus1 == BpAddr)) begin
            state_next = FS_IDLE;
            bp_set     = 1'b1;
          end
`endif
        end else if (bus.LoadReq) begin
          latch_load    = 1'b1;
          ret_exec_next = 1'b1;
          state_next    = FS_LOAD;
        end
      end
      FS_LOAD: begin
        // Overwriting the word being executed forces a refetch.
        if (!ret_exec)
          state_next = FS_IDLE;
        else if (load_addr == PC)
          state_next = FS_FETCH;
        else
          state_next = FS_EXEC;
      end
      default: state_next = FS_IDLE;
    endcase
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state    <= FS_IDLE;
      ret_exec <= 1'b0;
    end else begin
      state    <= state_next;
      ret_exec <= ret_exec_next;
    end
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      load_addr <= '0;
      load_data <= '0;
    end else if (latch_load) begin
      load_addr <= bus.LoadAddr;
      load_data <= bus.LoadData;
    end
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn)
      lat_cnt <= '0;
    else if ((state == FS_FETCH) && !fetch_done)
      lat_cnt <= lat_cnt + CNT_W'(1);
    else
      lat_cnt <= '0;
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn)
      bus.ProcDIN <= '0;
    else if (fetch_done)
      bus.ProcDIN <= bus.MemQ;
  end

`ifdef FETCH_SEQ_BREAKPOINT_EN
  // Sticky until the next accepted Start.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn)
      BpHit <= 1'b0;
    else if (bp_set)
      BpHit <= 1'b1;
    else if (bp_clear)
      BpHit <= 1'b0;
  end
`endif

endmodule
